// File: rtl/cpu_trace_fifo.sv
// rtl/cpu_trace_fifo.sv - trace capture FIFO for the accumulator CPU with valid/ready drain
// Optional build macro CPU_TRACE_TIMESTAMP_EN appends a 16-bit capture timestamp to each record.
module cpu_trace_fifo #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1,
`ifdef CPU_TRACE_TIMESTAMP_EN
   localparam int REC_W = 41
`else
   localparam int REC_W = 25
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       cpu_pc,
   input  logic [15:0]      cpu_out,
   input  logic             cpu_exit,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [REC_W-1:0] m_data,
   output logic [LVL_W-1:0] level,
   output logic [CNT_W-1:0] drop_cnt,
   output logic             done
);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [REC_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [LVL_W-1:0] level_nxt;
   logic [15:0]      prev_out;
   logic             exit_q, exit_pend;
   logic             full, empty, pop, can_push;
   logic             data_ev, exit_rise, push_data, push_exit, push, drop;
   logic [REC_W-1:0] wr_rec;

   always_comb begin
      full      = (level == FULL_LVL);
      empty     = (level == '0);
      pop       = m_valid && m_ready;
      can_push  = !full || pop;
      data_ev   = (state == S_RUN) && (cpu_out != prev_out);
      exit_rise = cpu_exit && !exit_q;
      push_data = data_ev && can_push;
      drop      = data_ev && !can_push;
      // A pending EXIT only takes a slot on cycles without a data event.
      push_exit = (state == S_RUN) && !data_ev && exit_pend && can_push;
      push      = push_data || push_exit;
      level_nxt = level;
      if (push && !pop)
         level_nxt = level + LVL_ONE;
      else if (!push && pop)
         level_nxt = level - LVL_ONE;
   end

`ifdef CPU_TRACE_TIMESTAMP_EN
   logic [15:0] ts;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ts <= '0;
      else
         ts <= ts + 16'd1;
   end

   assign wr_rec = {push_exit, cpu_pc, cpu_out, ts};
`else
   assign wr_rec = {push_exit, cpu_pc, cpu_out};
`endif

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_rec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         drop_cnt  <= '0;
         prev_out  <= '0;
         exit_q    <= 1'b0;
         exit_pend <= 1'b0;
      end else begin
         prev_out  <= cpu_out;
         exit_q    <= cpu_exit;
         exit_pend <= (exit_pend && !push_exit) || exit_rise;
         level     <= level_nxt;
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (drop && (drop_cnt != '1))
            drop_cnt <= drop_cnt + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN:   if (push_exit) state_nxt = S_DRAIN;
         S_DRAIN: if (level_nxt == '0) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_DONE;
         default: state_nxt = S_RUN;
      endcase
   end

   // Gating m_data keeps it zero while empty, since the storage array is not reset.
   always_comb begin
      m_valid = !empty && (state != S_DONE);
      done    = (state == S_DONE);
      m_data  = m_valid ? mem[rd_ptr] : '0;
   end

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// tb/tb_cpu_trace_fifo.sv - randomized self-checking bench for cpu_trace_fifo
module tb_cpu_trace_fifo;
   localparam int DEPTH = 8;
`ifdef CPU_TRACE_TIMESTAMP_EN
   localparam int REC_W = 41;
`else
   localparam int REC_W = 25;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       cpu_pc = '0;
   logic [15:0]      cpu_out = '0;
   logic             cpu_exit = 1'b0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [REC_W-1:0] m_data;
   logic [3:0]       level;
   logic [15:0]      drop_cnt;
   logic             done;

   int checks = 0;
   int failures = 0;
   bit chk_en = 0;

   logic [24:0] mq[$];
   int          mdrop;
   bit          mdone, mdrain, mpend, mexq;
   logic [15:0] mprev;

   cpu_trace_fifo #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .cpu_pc(cpu_pc), .cpu_out(cpu_out), .cpu_exit(cpu_exit),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level),
      .drop_cnt(drop_cnt), .done(done)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      mdrop  = 0;
      mdone  = 0;
      mdrain = 0;
      mpend  = 0;
      mexq   = 0;
      mprev  = '0;
   endtask

   task automatic model_step();
      bit popm, room, dev, rise;
      popm = (mq.size() > 0) && !mdone && m_ready;
      room = (mq.size() < DEPTH) || popm;
      dev  = !mdrain && !mdone && (cpu_out != mprev);
      rise = cpu_exit && !mexq;
      if (popm) void'(mq.pop_front());
      if (dev) begin
         if (room) mq.push_back({1'b0, cpu_pc, cpu_out});
         else if (mdrop < 16'hFFFF) mdrop++;
      end else if (!mdrain && !mdone && mpend && room) begin
         mq.push_back({1'b1, cpu_pc, cpu_out});
         mpend  = 0;
         mdrain = 1;
      end
      if (rise) mpend = 1;
      if (mdrain && mq.size() == 0) mdone = 1;
      mprev = cpu_out;
      mexq  = cpu_exit;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      model_reset();
      cpu_out  = '0;
      cpu_pc   = '0;
      cpu_exit = 1'b0;
      m_ready  = 1'b0;
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_level", level, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("m_valid", m_valid, (mq.size() > 0) && !mdone);
         if (m_valid && mq.size() > 0) chk("m_data", m_data[REC_W-1 -: 25], mq[0]);
         chk("level", level, mq.size());
         chk("drop_cnt", drop_cnt, mdrop);
         chk("done", done, mdone);
      end
   end

   initial begin
      logic [24:0] last;
      bit          prev_valid, seen;
      @(negedge clk);
      do_reset();
      chk_en = 1;

      // single change after reset
      m_ready = 1'b1;
      repeat (3) step();
      cpu_out = 16'h0005;
      cpu_pc  = 8'h12;
      step();
      chk("t1_valid", m_valid, 1);
      chk("t1_data", m_data[REC_W-1 -: 25], 25'h0120005);
      step();
      chk("t1_valid_after", m_valid, 0);

      // overflow with sink stalled
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cpu_out = 16'(16'h0111 * (i + 1));
         cpu_pc  = 8'(8'h20 + i);
         step();
      end
      chk("t2_level", level, 8);
      chk("t2_drop", drop_cnt, 2);
      chk("t2_head", m_data[REC_W-1 -: 25], 25'h0200111);

      // push and pop together while full
      m_ready = 1'b1;
      cpu_out = 16'hBBBB;
      cpu_pc  = 8'h2A;
      step();
      chk("t3_level", level, 8);
      chk("t3_drop", drop_cnt, 2);
      chk("t3_head", m_data[REC_W-1 -: 25], 25'h0210222);
      repeat (10) step();
      chk("t3_drained", level, 0);

      // randomized traffic, exit raised late in the last round
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 200; c++) begin
            m_ready = ($urandom_range(0, 3) < r + 1);
            if ($urandom_range(0, 1) == 1) cpu_out = 16'($urandom_range(0, 7));
            cpu_pc = 8'($urandom);
            if (r == 2 && c == 150) cpu_exit = 1'b1;
            step();
         end
      end
      m_ready = 1'b1;
      repeat (20) step();
      chk("rand_done", done, 1);

      // exit while full and stalled
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cpu_out = 16'(16'h1000 + i);
         cpu_pc  = 8'(i);
         step();
      end
      cpu_exit = 1'b1;
      repeat (5) step();
      chk("t4_level", level, 8);
      chk("t4_done_early", done, 0);
      m_ready = 1'b1;
      last = '0;
      prev_valid = 0;
      seen = 0;
      for (int k = 0; k < 40 && !seen; k++) begin
         prev_valid = m_valid;
         if (m_valid) last = m_data[REC_W-1 -: 25];
         step();
         if (done) seen = 1;
      end
      chk("t4_done_seen", seen, 1);
      chk("t4_last_kind", last[24], 1);
      chk("t4_pop_before_done", prev_valid, 1);
      chk("t4_valid_done", m_valid, 0);

      // data and exit on the same edge
      do_reset();
      m_ready  = 1'b1;
      cpu_out  = 16'h0ABC;
      cpu_pc   = 8'h55;
      cpu_exit = 1'b1;
      step();
      chk("t5_data", m_data[REC_W-1 -: 25], 25'h0550ABC);
      step();
      chk("t5_exit", m_data[REC_W-1 -: 25], 25'h1550ABC);
      for (int i = 0; i < 4; i++) begin
         cpu_out = 16'(16'h2000 + i);
         step();
      end
      chk("t5_done", done, 1);
      chk("t5_level", level, 0);
      chk("t5_drop", drop_cnt, 0);

      // reset mid-drain
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cpu_out = 16'(16'h0301 + i);
         step();
      end
      chk("t6_level", level, 5);
      m_ready = 1'b1;
      do_reset();
      m_ready = 1'b1;
      cpu_out = 16'h0077;
      cpu_pc  = 8'h09;
      step();
      chk("t6_recover", m_data[REC_W-1 -: 25], 25'h0090077);
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
